// File: rtl/beamformer_pkg.sv
// Constants and state encodings shared between the UART word receiver and the TX readout.
package beamformer_pkg;

  localparam int unsigned WORD_BYTES   = 5;
  localparam int unsigned WORD_W       = 8 * WORD_BYTES;
  localparam int unsigned NUM_WORDS    = 540;
  localparam int unsigned ADDR_W       = 10;
  localparam int unsigned CLKS_PER_BIT = 868;

  typedef enum logic [1:0] {
    BitIdle,
    BitStart,
    BitData,
    BitStop
  } bit_state_e;

  typedef enum logic [1:0] {
    WordDisarmed,
    WordRecv,
    WordDone
  } word_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, baud counter and bit FSM.
// Emits one-cycle byte_valid (good stop bit) or byte_err (stop bit low) pulses.
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = beamformer_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);
  import beamformer_pkg::*;

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

  bit_state_e    state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          fall;
  logic          half_end, bit_end;

  assign fall     = rx_prev_q & ~rx_sync_q;
  assign half_end = (cnt_q == CntW'(CLKS_PER_BIT / 2 - 1));
  assign bit_end  = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Idle line is high; presetting avoids a false start edge out of reset.
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= BitIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      unique case (state_q)
        BitIdle: begin
          if (fall) begin
            state_q <= BitStart;
            cnt_q   <= '0;
          end
        end
        BitStart: begin
          if (half_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_sync_q ? BitIdle : BitData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BitData: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= BitStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BitStop: begin
          if (bit_end) begin
            cnt_q      <= '0;
            byte_data  <= shift_q;
            byte_valid <= rx_sync_q;
            byte_err   <= ~rx_sync_q;
            state_q    <= fall ? BitStart : BitIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= BitIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// UART word loader: packs 8N1 bytes LSB-first into words and writes them to a word RAM.
// Optional partial-word timeout enabled by defining UART_WORD_RX_TIMEOUT_EN.
module uart_word_rx #(
  parameter int unsigned CLKS_PER_BIT = beamformer_pkg::CLKS_PER_BIT,
  parameter int unsigned WORD_BYTES   = beamformer_pkg::WORD_BYTES,
  parameter int unsigned NUM_WORDS    = beamformer_pkg::NUM_WORDS,
  parameter int unsigned ADDR_W       = beamformer_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx,
  input  logic                    start,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [8*WORD_BYTES-1:0] ram_data,
  output logic                    ram_wren,
  output logic                    busy,
  output logic                    done,
  output logic                    frame_err,
  output logic [ADDR_W-1:0]       word_count
);
  import beamformer_pkg::*;

  localparam int unsigned WordW = 8 * WORD_BYTES;
  localparam int unsigned IdxW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [7:0]       byte_data;
  logic             byte_valid, byte_err;
  word_state_e      state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WordW-1:0] word_q, word_next;
  logic             tmo_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  always_comb begin
    word_next = word_q;
    word_next[8*idx_q +: 8] = byte_data;
  end

`ifdef UART_WORD_RX_TIMEOUT_EN
  localparam int unsigned TmoCycles = 20 * CLKS_PER_BIT;
  localparam int unsigned TmoW      = $clog2(TmoCycles);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            tmo_run;

  assign tmo_run = (state_q == WordRecv) && (idx_q != '0) && !start;
  assign tmo_hit = tmo_run && !byte_valid && !byte_err &&
                   (tmo_cnt_q == TmoW'(TmoCycles - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (!tmo_run || byte_valid || byte_err || tmo_hit) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WordDisarmed;
      idx_q      <= '0;
      word_q     <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      word_count <= '0;
    end else begin
      ram_wren <= 1'b0;
      if (start) begin
        // Start wins over any byte completing this cycle.
        state_q    <= WordRecv;
        busy       <= 1'b1;
        done       <= 1'b0;
        frame_err  <= 1'b0;
        idx_q      <= '0;
        ram_addr   <= '0;
        word_count <= '0;
      end else begin
        unique case (state_q)
          WordDisarmed: ;
          WordRecv: begin
            if (ram_wren) begin
              word_count <= word_count + 1'b1;
              if (ram_addr == ADDR_W'(NUM_WORDS - 1)) begin
                state_q <= WordDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                ram_addr <= ram_addr + 1'b1;
              end
            end
            if (byte_valid) begin
              if (idx_q == IdxW'(WORD_BYTES - 1)) begin
                ram_wren <= 1'b1;
                ram_data <= word_next;
                idx_q    <= '0;
              end else begin
                word_q <= word_next;
                idx_q  <= idx_q + 1'b1;
              end
            end else if (byte_err || tmo_hit) begin
              frame_err <= 1'b1;
              idx_q     <= '0;
            end
          end
          WordDone: ;
          default: state_q <= WordDisarmed;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx at 16 clocks per bit and 3 words per transfer.
module tb_uart_word_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        start;
  logic [9:0]  ram_addr;
  logic [39:0] ram_data;
  logic        ram_wren;
  logic        busy;
  logic        done;
  logic        frame_err;
  logic [9:0]  word_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int byte_start_cyc = 0;
  int last_wr_cyc    = 0;
  logic [9:0]  wr_addr [$];
  logic [39:0] wr_data [$];

  uart_word_rx #(
    .CLKS_PER_BIT(16),
    .WORD_BYTES  (5),
    .NUM_WORDS   (3),
    .ADDR_W      (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .start     (start),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .busy      (busy),
    .done      (done),
    .frame_err (frame_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_wren) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_data);
      last_wr_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    #1;
    byte_start_cyc = cyc;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(16);
    end
    rx = stop_bit;
    tick(16);
    rx = 1'b1;
    tick(4);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    start = 1'b0;
    tick(3);
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_data", 64'(ram_data), 64'd0);
    check("rst_wren", 64'(ram_wren), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_wcnt", 64'(word_count), 64'd0);
    rst_n = 1'b1;
    tick(40);
    check("idle_no_wr", 64'(wr_addr.size()), 64'd0);

    // Single word; write strobe one cycle after the stop-bit sample
    clear_log();
    pulse_start();
    check("t2_busy", 64'(busy), 64'd1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h01, 1'b1);
    tick(2);
    check("t2_nwr", 64'(wr_addr.size()), 64'd1);
    check("t2_addr", 64'((wr_addr.size() > 0) ? wr_addr[0] : 10'h3ff), 64'd0);
    check("t2_data", 64'((wr_data.size() > 0) ? wr_data[0] : 40'h0), 64'h0102030405);
    check("t2_lat", 64'(last_wr_cyc - byte_start_cyc), 64'd156);
    check("t2_wcnt", 64'(word_count), 64'd1);
    check("t2_done", 64'(done), 64'd0);

    // Full transfer of 3 words, then an ignored extra byte
    clear_log();
    pulse_start();
    check("t3_wcnt0", 64'(word_count), 64'd0);
    for (int k = 0; k < 15; k++) send_byte(8'h10 + 8'(k), 1'b1);
    tick(2);
    check("t3_nwr", 64'(wr_addr.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      check("t3_addr", 64'((wr_addr.size() > k) ? wr_addr[k] : 10'h3ff), 64'(k));
    check("t3_data2", 64'((wr_data.size() > 2) ? wr_data[2] : 40'h0), 64'h1E1D1C1B1A);
    check("t3_done", 64'(done), 64'd1);
    check("t3_busy", 64'(busy), 64'd0);
    check("t3_wcnt", 64'(word_count), 64'd3);
    send_byte(8'h99, 1'b1);
    tick(2);
    check("t3_extra", 64'(wr_addr.size()), 64'd3);
    check("t3_addrmax", 64'(ram_addr), 64'd2);

    // Framing error discards the partial word, address stays at 0
    clear_log();
    pulse_start();
    check("t4_done", 64'(done), 64'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b0);
    check("t4_ferr", 64'(frame_err), 64'd1);
    check("t4_nowr", 64'(wr_addr.size()), 64'd0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    send_byte(8'hEE, 1'b1);
    tick(2);
    check("t4_nwr", 64'(wr_addr.size()), 64'd1);
    check("t4_addr", 64'((wr_addr.size() > 0) ? wr_addr[0] : 10'h3ff), 64'd0);
    check("t4_data", 64'((wr_data.size() > 0) ? wr_data[0] : 40'h0), 64'hEEDDCCBBAA);
    check("t4_ferr_held", 64'(frame_err), 64'd1);
    pulse_start();
    check("t4_ferr_clr", 64'(frame_err), 64'd0);

    // Short low glitch must not produce a byte
    clear_log();
    tick(1);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(40);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    tick(2);
    check("t5_nwr", 64'(wr_addr.size()), 64'd1);
    check("t5_addr", 64'((wr_addr.size() > 0) ? wr_addr[0] : 10'h3ff), 64'd0);
    check("t5_data", 64'((wr_data.size() > 0) ? wr_data[0] : 40'h0), 64'h5544332211);
    check("t5_ferr", 64'(frame_err), 64'd0);

`ifdef UART_WORD_RX_TIMEOUT_EN
    clear_log();
    pulse_start();
    send_byte(8'h61, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h63, 1'b1);
    tick(330);
    check("t6_ferr", 64'(frame_err), 64'd1);
    check("t6_nowr", 64'(wr_addr.size()), 64'd0);
    send_byte(8'h71, 1'b1);
    send_byte(8'h72, 1'b1);
    send_byte(8'h73, 1'b1);
    send_byte(8'h74, 1'b1);
    send_byte(8'h75, 1'b1);
    tick(2);
    check("t6_nwr", 64'(wr_addr.size()), 64'd1);
    check("t6_addr", 64'((wr_addr.size() > 0) ? wr_addr[0] : 10'h3ff), 64'd0);
    check("t6_data", 64'((wr_data.size() > 0) ? wr_data[0] : 40'h0), 64'h7574737271);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
